io_bus_sequencer: RTL and testbench

//  Sequences bus transactions into the 3-port programmable I/O interface (control reg + ports A/B/C).
//  Two requesters share it; a round-robin arbiter grants one at a time.
//  An FSM generates address/data setup, a wr/rd strobe of programmable width and read-data capture.

---
 rtl/io_ctl_pkg.sv | 17 +
 rtl/rr_arb2.sv | 30 +++
 rtl/io_bus_sequencer.sv | 144 ++++++++++++++
 tb/tb_io_bus_sequencer.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/io_ctl_pkg.sv
// Shared types and constants for the I/O bus sequencer: FSM state encoding and
// the register map of the 3-port I/O interface.
package io_ctl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam logic [1:0] IO_ADDR_CTL = 2'd0;
    localparam logic [1:0] IO_ADDR_A   = 2'd1;
    localparam logic [1:0] IO_ADDR_B   = 2'd2;
    localparam logic [1:0] IO_ADDR_C   = 2'd3;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. A lone requester always wins; on a tie the
// requester that did not win last time is granted. Reset favours requester 0.
module rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic last_gnt;

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_gnt ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            last_gnt <= 1'b1;
        else if (advance && (req != 2'b00))
            last_gnt <= gnt[1];
    end

endmodule

// File: rtl/io_bus_sequencer.sv
// Sequences arbitrated bus transactions into the 3-port I/O interface:
// address/data setup, programmable-width wr/rd strobe, read capture, ack.
module io_bus_sequencer
    import io_ctl_pkg::*;
#(
    parameter int SETUP_CYCLES  = 1,
    parameter int STROBE_CYCLES = 1,
    parameter int CNT_W         = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [1:0]  req_i,
    input  logic [1:0]  we_i,
    input  logic [3:0]  addr_i,
    input  logic [15:0] wdata_i,
    output logic [1:0]  ack_o,
    output logic [7:0]  rdata_o,
    output logic        busy_o,
    output logic [1:0]  io_dir_o,
    output logic [7:0]  io_data_o,
    output logic        io_wr_o,
    output logic        io_rd_o,
    input  logic [7:0]  io_data_i
);

    localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYCLES - 1);

    state_e           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             tx_we, tx_we_nxt;
    logic             tx_id, tx_id_nxt;
    logic [1:0]       gnt;
    logic             advance;

    logic [1:0]       ack_nxt;
    logic [7:0]       rdata_nxt;
    logic             busy_nxt;
    logic [1:0]       dir_nxt;
    logic [7:0]       data_nxt;
    logic             wr_nxt;
    logic             rd_nxt;

    assign advance = (state == IDLE) && (req_i != 2'b00);

    rr_arb2 u_arb (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .req     (req_i),
        .advance (advance),
        .gnt     (gnt)
    );

    // State, counter, transaction latch and every output are flopped together
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= IDLE;
            cnt       <= '0;
            tx_we     <= 1'b0;
            tx_id     <= 1'b0;
            ack_o     <= 2'b00;
            rdata_o   <= 8'h00;
            busy_o    <= 1'b0;
            io_dir_o  <= IO_ADDR_CTL;
            io_data_o <= 8'h00;
            io_wr_o   <= 1'b0;
            io_rd_o   <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            tx_we     <= tx_we_nxt;
            tx_id     <= tx_id_nxt;
            ack_o     <= ack_nxt;
            rdata_o   <= rdata_nxt;
            busy_o    <= busy_nxt;
            io_dir_o  <= dir_nxt;
            io_data_o <= data_nxt;
            io_wr_o   <= wr_nxt;
            io_rd_o   <= rd_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (req_i != 2'b00) begin
                    state_nxt = SETUP;
                    cnt_nxt   = SETUP_LD;
                end
            end
            SETUP: begin
                if (cnt == '0) begin
                    state_nxt = STROBE;
                    cnt_nxt   = STROBE_LD;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            STROBE: begin
                if (cnt == '0)
                    state_nxt = DONE;
                else
                    cnt_nxt = cnt - 1'b1;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are computed one cycle ahead from state_nxt so the registered
    // strobe and ack line up exactly with the STROBE and DONE states.
    always_comb begin
        tx_we_nxt = tx_we;
        tx_id_nxt = tx_id;
        dir_nxt   = io_dir_o;
        data_nxt  = io_data_o;
        rdata_nxt = rdata_o;
        ack_nxt   = 2'b00;
        busy_nxt  = (state_nxt != IDLE);
        wr_nxt    = 1'b0;
        rd_nxt    = 1'b0;

        if (advance) begin
            tx_id_nxt = gnt[1];
            tx_we_nxt = gnt[1] ? we_i[1] : we_i[0];
            dir_nxt   = gnt[1] ? addr_i[3:2] : addr_i[1:0];
            data_nxt  = gnt[1] ? wdata_i[15:8] : wdata_i[7:0];
        end

        if (state_nxt == STROBE) begin
            wr_nxt = tx_we;
            rd_nxt = ~tx_we;
        end

        if ((state == STROBE) && (cnt == '0) && !tx_we)
            rdata_nxt = io_data_i;

        if (state_nxt == DONE)
            ack_nxt = tx_id ? 2'b10 : 2'b01;
    end

endmodule

// File: tb/tb_io_bus_sequencer.sv
// Directed bench for io_bus_sequencer: default-timing instance plus a
// SETUP=2/STROBE=3 instance for the programmable-width case.
module tb_io_bus_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req, we;
    logic [3:0]  addr;
    logic [15:0] wdata;
    logic [7:0]  io_din;
    logic [1:0]  ack;
    logic [7:0]  rdata;
    logic        busy, io_wr, io_rd;
    logic [1:0]  io_dir;
    logic [7:0]  io_data;

    logic [1:0]  req2, we2;
    logic [3:0]  addr2;
    logic [15:0] wdata2;
    logic [1:0]  ack2;
    logic [7:0]  rdata2;
    logic        busy2, io_wr2, io_rd2;
    logic [1:0]  io_dir2;
    logic [7:0]  io_data2;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    io_bus_sequencer dut (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .addr_i(addr),
        .wdata_i(wdata), .ack_o(ack), .rdata_o(rdata), .busy_o(busy),
        .io_dir_o(io_dir), .io_data_o(io_data), .io_wr_o(io_wr),
        .io_rd_o(io_rd), .io_data_i(io_din)
    );

    io_bus_sequencer #(.SETUP_CYCLES(2), .STROBE_CYCLES(3), .CNT_W(4)) dut2 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req2), .we_i(we2), .addr_i(addr2),
        .wdata_i(wdata2), .ack_o(ack2), .rdata_o(rdata2), .busy_o(busy2),
        .io_dir_o(io_dir2), .io_data_o(io_data2), .io_wr_o(io_wr2),
        .io_rd_o(io_rd2), .io_data_i(io_din)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; req = 0; we = 0; addr = 0; wdata = 0; io_din = 8'h00;
        req2 = 0; we2 = 0; addr2 = 0; wdata2 = 0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_ack", ack, 2'b00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_strobes", {io_wr, io_rd}, 2'b00);
        chk("rst_dir_data", {io_dir, io_data}, 10'h000);
        chk("rst_rdata", rdata, 8'h00);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: single write, requester 0, control reg, 0x03
        req = 2'b01; we = 2'b01; addr = 4'h0; wdata = 16'h0003;
        @(negedge clk);
        chk("w_setup_busy", busy, 1'b1);
        chk("w_setup_dirdata", {io_dir, io_data}, {2'd0, 8'h03});
        chk("w_setup_strb", {io_wr, io_rd, ack}, 4'b0000);
        @(negedge clk);
        chk("w_strobe", {io_wr, io_rd, ack}, 4'b1000);
        @(negedge clk);
        chk("w_done", {io_wr, io_rd, ack}, 4'b0001);
        req = 2'b00;
        @(negedge clk);
        chk("w_idle", {busy, io_wr, io_rd, ack}, 5'b00000);
        chk("w_hold_data", io_data, 8'h03);

        // 2: single read, requester 1, port C
        req = 2'b10; we = 2'b00; addr = 4'b1100; io_din = 8'hA5;
        @(negedge clk);
        chk("r_setup_dir", io_dir, 2'd3);
        chk("r_setup_strb", {io_wr, io_rd}, 2'b00);
        @(negedge clk);
        chk("r_strobe", {io_wr, io_rd, ack}, 4'b0100);
        @(negedge clk);
        chk("r_ack", ack, 2'b10);
        chk("r_rdata", rdata, 8'hA5);
        chk("r_done_strb", {io_wr, io_rd}, 2'b00);
        req = 2'b00; io_din = 8'h5A;
        @(negedge clk);
        chk("r_rdata_hold", rdata, 8'hA5);
        chk("r_ack_off", ack, 2'b00);

        // 3: both request, held -> 0,1,0,1
        req = 2'b11; we = 2'b11; addr = 4'b0110; wdata = 16'h2211;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            chk($sformatf("rr_ack_%0d", i), ack,
                (i % 4 == 3) ? (((i / 4) % 2 == 1) ? 2'b10 : 2'b01) : 2'b00);
            chk($sformatf("rr_excl_%0d", i), io_wr & io_rd, 1'b0);
            if (i == 1) chk("rr_dir0", io_dir, 2'd2);
            if (i == 2) chk("rr_data0", {io_wr, io_data}, {1'b1, 8'h11});
            if (i == 5) chk("rr_dir1", io_dir, 2'd1);
            if (i == 6) chk("rr_data1", {io_wr, io_data}, {1'b1, 8'h22});
            if (i == 15) req = 2'b00;
        end
        @(negedge clk);
        chk("rr_idle", busy, 1'b0);

        // 6: mid-transaction input changes and req drop are ignored
        req = 2'b01; we = 2'b01; addr = 4'b0001; wdata = 16'h0044;
        @(negedge clk);
        chk("mid_dir1", {io_dir, io_data}, {2'd1, 8'h44});
        req = 2'b00; addr = 4'b0010; wdata = 16'h0099; we = 2'b00;
        @(negedge clk);
        chk("mid_strobe", {io_wr, io_rd, io_dir, io_data}, {2'b10, 2'd1, 8'h44});
        @(negedge clk);
        chk("mid_ack", {ack, io_dir, io_data}, {2'b01, 2'd1, 8'h44});
        @(negedge clk);
        chk("mid_hold", {busy, io_dir, io_data}, {1'b0, 2'd1, 8'h44});

        // 5: reset during STROBE, then tie goes to requester 0
        req = 2'b01; we = 2'b01; addr = 4'b0010; wdata = 16'h0077;
        @(negedge clk);
        @(negedge clk);
        chk("rs_pre_wr", io_wr, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("rs_async", {io_wr, io_rd, ack, busy}, 5'b00000);
        req = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rs_no_ack", {ack, busy}, 3'b000);
        req = 2'b11; we = 2'b00; addr = 4'b1101; io_din = 8'h3C;
        @(negedge clk);
        chk("rs_tie_dir", io_dir, 2'd1);
        @(negedge clk);
        chk("rs_tie_rd", {io_wr, io_rd}, 2'b01);
        @(negedge clk);
        chk("rs_tie_ack", {ack, rdata}, {2'b01, 8'h3C});
        req = 2'b00;
        @(negedge clk);

        // 4: SETUP=2, STROBE=3 write on the second instance
        req2 = 2'b10; we2 = 2'b10; addr2 = 4'b1100; wdata2 = 16'h5C00;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            chk($sformatf("long_wr_%0d", i), {io_wr2, io_rd2},
                (i >= 3 && i <= 5) ? 2'b10 : 2'b00);
            chk($sformatf("long_ack_%0d", i), ack2, (i == 6) ? 2'b10 : 2'b00);
            if (i == 1) chk("long_dirdata", {io_dir2, io_data2}, {2'd3, 8'h5C});
            if (i == 6) req2 = 2'b00;
        end
        chk("long_idle", busy2, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
